// File: rtl/approx_mult_pkg.sv
// rtl/approx_mult_pkg.sv - shared level encodings and constants for the approximate multiplier
package approx_mult_pkg;

  typedef logic [1:0] lvl_t;

  localparam lvl_t LVL_EXACT = 2'd0;
  localparam lvl_t LVL_1     = 2'd1;
  localparam lvl_t LVL_2     = 2'd2;
  localparam lvl_t LVL_3     = 2'd3;

  localparam logic [7:0] MODE_RST = 8'b10_11_11_11;
  localparam int         LAT      = 3;

  function automatic lvl_t mode_lvl(input logic [7:0] mode, input int q);
    return mode[2*q +: 2];
  endfunction

endpackage

// File: rtl/approx_pp.sv
// rtl/approx_pp.sv - one H x H quadrant multiplier with level-driven low-bit truncation
module approx_pp
  import approx_mult_pkg::*;
#(
  parameter int H = 4
) (
  input  logic [H-1:0]   a,
  input  logic [H-1:0]   b,
  input  lvl_t           lvl,
  output logic [2*H-1:0] t
);

  // each level step clears W/8 = H/4 low bits of the exact product
  localparam int STEP = H / 4;

  logic [2*H-1:0] p;
  logic [2*H-1:0] mask;
  int unsigned    sh;

  always_comb begin
    p = {{H{1'b0}}, a} * {{H{1'b0}}, b};
    case (lvl)
      LVL_EXACT: sh = 0;
      LVL_1:     sh = STEP;
      LVL_2:     sh = 2 * STEP;
      default:   sh = 3 * STEP;
    endcase
    mask = {(2*H){1'b1}} << sh;
    t    = p & mask;
  end

endmodule

// File: rtl/approx_mult_pipe.sv
// rtl/approx_mult_pipe.sv - three-stage approximate unsigned multiplier with per-quadrant truncation
module approx_mult_pipe
  import approx_mult_pkg::*;
#(
  parameter int W     = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic             cfg_we,
  input  logic [7:0]       cfg_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*W-1:0]   out_r,
  output logic [CNT_W-1:0] op_count
);

  localparam int H = W / 2;

  if (W < 8 || (W % 8) != 0) begin : g_bad_w
    $error("approx_mult_pipe: W must be a positive multiple of 8");
  end

  logic           en;
  logic [7:0]     mode_q;

  logic           s1_v;
  logic [W-1:0]   s1_a;
  logic [W-1:0]   s1_b;
  logic [7:0]     s1_mode;

  logic [H-1:0]   qa [4];
  logic [H-1:0]   qb [4];
  logic [W-1:0]   pp_t [4];

  logic           s2_v;
  logic [W-1:0]   s2_t [4];
  logic [2*W-1:0] sum;

  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  // the mode register is independent of the pipeline enable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= MODE_RST;
    end else if (cfg_we) begin
      mode_q <= cfg_mode;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v    <= 1'b0;
      s1_a    <= '0;
      s1_b    <= '0;
      s1_mode <= MODE_RST;
    end else if (en) begin
      s1_v <= in_valid;
      if (in_valid) begin
        s1_a    <= in_a;
        s1_b    <= in_b;
        s1_mode <= mode_q;
      end
    end
  end

  assign qa[0] = s1_a[H-1:0];
  assign qb[0] = s1_b[H-1:0];
  assign qa[1] = s1_a[H-1:0];
  assign qb[1] = s1_b[W-1:H];
  assign qa[2] = s1_a[W-1:H];
  assign qb[2] = s1_b[H-1:0];
  assign qa[3] = s1_a[W-1:H];
  assign qb[3] = s1_b[W-1:H];

  for (genvar q = 0; q < 4; q++) begin : g_pp
    approx_pp #(.H(H)) u_pp (
      .a   (qa[q]),
      .b   (qb[q]),
      .lvl (mode_lvl(s1_mode, q)),
      .t   (pp_t[q])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_v <= 1'b0;
      for (int q = 0; q < 4; q++) begin
        s2_t[q] <= '0;
      end
    end else if (en) begin
      s2_v <= s1_v;
      if (s1_v) begin
        for (int q = 0; q < 4; q++) begin
          s2_t[q] <= pp_t[q];
        end
      end
    end
  end

  assign sum = (2*W)'(s2_t[0])
             + ((2*W)'(s2_t[1]) << H)
             + ((2*W)'(s2_t[2]) << H)
             + ((2*W)'(s2_t[3]) << W);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_r     <= '0;
    end else if (en) begin
      out_valid <= s2_v;
      if (s2_v) begin
        out_r <= sum;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count <= '0;
    end else if (out_valid && out_ready && (op_count != {CNT_W{1'b1}})) begin
      op_count <= op_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_approx_mult_pipe.sv
// tb/tb_approx_mult_pipe.sv - scoreboard bench for approx_mult_pipe
module tb_approx_mult_pipe;
  import approx_mult_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_a = '0;
  logic [7:0]  in_b = '0;
  logic        cfg_we = 1'b0;
  logic [7:0]  cfg_mode = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_r;
  logic [15:0] op_count;

  logic        in_ready_s;
  logic        out_valid_s;
  logic [15:0] out_r_s;
  logic [2:0]  op_count_s;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          n_sent = 0;
  logic        waited = 1'b0;
  logic [7:0]  tb_mode = MODE_RST;
  logic [15:0] sb[$];
  logic [15:0] got[$];
  int          xfer_cyc[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  approx_mult_pipe #(.W(8), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .cfg_we(cfg_we), .cfg_mode(cfg_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_r(out_r), .op_count(op_count)
  );

  approx_mult_pipe #(.W(8), .CNT_W(3)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
    .in_a(in_a), .in_b(in_b), .cfg_we(cfg_we), .cfg_mode(cfg_mode),
    .out_valid(out_valid_s), .out_ready(out_ready), .out_r(out_r_s), .op_count(op_count_s)
  );

  function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b,
                                        input logic [7:0] m);
    int p[4];
    int k;
    int s;
    p[0] = (a % 16) * (b % 16);
    p[1] = (a % 16) * (b / 16);
    p[2] = (a / 16) * (b % 16);
    p[3] = (a / 16) * (b / 16);
    for (int q = 0; q < 4; q++) begin
      k    = (int'(m) >> (2 * q)) & 3;
      p[q] = (p[q] / (1 << k)) * (1 << k);
    end
    s = p[0] + (p[1] + p[2]) * 16 + p[3] * 256;
    return 16'(s);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // result monitor: values sampled here are those seen by the next rising edge
  always @(negedge clk) begin
    #1;
    if (rst_n && out_valid && out_ready) begin
      chk("unexpected_out", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        chk("out_r", 32'(out_r), 32'(sb.pop_front()));
      end
      got.push_back(out_r);
      xfer_cyc.push_back(cyc);
    end
  end

  task automatic send(input logic [7:0] a, input logic [7:0] b,
                      input logic we = 1'b0, input logic [7:0] m = 8'h00);
    @(negedge clk);
    in_a = a; in_b = b; in_valid = 1'b1; cfg_we = we; cfg_mode = m;
    #1;
    for (int i = 0; i < 50 && !in_ready; i++) begin
      waited = 1'b1;
      @(negedge clk);
      #1;
    end
    chk("accept", 32'(in_ready), 32'd1);
    sb.push_back(model(a, b, tb_mode));
    if (we) tb_mode = m;
    n_sent++;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    cfg_we = 1'b0;
  endtask

  task automatic cfg(input logic [7:0] m);
    @(negedge clk);
    cfg_we = 1'b1; cfg_mode = m;
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
    tb_mode = m;
  endtask

  task automatic wait_out(output int n);
    n = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      if (out_valid) break;
      n++;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && sb.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    chk("drain", 32'(sb.size()), 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int          lat;
    logic [15:0] held;
    int          nx;

    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_r", 32'(out_r), 32'd0);
    chk("rst_op_count", 32'(op_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("in_ready_after_rst", 32'(in_ready), 32'd1);

    send(8'd255, 8'd255);
    wait_out(lat);
    chk("latency_rst_mode", 32'(lat), 32'(LAT));
    chk("rst_mode_value", 32'(out_r), 32'd64736);
    drain();

    cfg(8'h00);
    send(8'd255, 8'd255);
    wait_out(lat);
    chk("latency_exact", 32'(lat), 32'(LAT));
    chk("exact_value", 32'(out_r), 32'd65025);
    drain();

    cfg(8'hE4); send(8'd200, 8'd77); send(8'd0, 8'd255);
    cfg(8'h55); send(8'd128, 8'd129); send(8'd1, 8'd1);
    cfg(8'h1B); send(8'd255, 8'd17); send(8'd99, 8'd201);
    cfg(8'hFF); send(8'd255, 8'd255); send(8'd15, 8'd240);
    drain();
    chk("op_count_mid", 32'(op_count), 32'(n_sent));

    // fill the three stages while downstream is blocked
    @(negedge clk);
    out_ready = 1'b0;
    send(8'd11, 8'd22); send(8'd33, 8'd44); send(8'd55, 8'd66);
    chk("bp_full_valid", 32'(out_valid), 32'd1);
    held = out_r;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_out_r_stable", 32'(out_r), 32'(held));
    end
    @(negedge clk);
    out_ready = 1'b1;
    drain();
    chk("bp_op_count", 32'(op_count), 32'(n_sent));

    send(8'd10, 8'd20); send(8'd30, 8'd40); send(8'd50, 8'd60);
    chk("flight_valid", 32'(out_valid), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_async_valid", 32'(out_valid), 32'd0);
    chk("rst_async_r", 32'(out_r), 32'd0);
    chk("rst_async_count", 32'(op_count), 32'd0);
    sb.delete();
    n_sent = 0;
    tb_mode = MODE_RST;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("in_ready_after_rst2", 32'(in_ready), 32'd1);
    repeat (6) @(negedge clk);
    #1;
    chk("no_stale_out", 32'(out_valid), 32'd0);
    chk("count_after_rst", 32'(op_count), 32'd0);

    send(8'd255, 8'd255, 1'b1, 8'h00);
    send(8'd255, 8'd255);
    drain();
    nx = got.size();
    chk("race_old_mode", 32'(got[nx-2]), 32'd64736);
    chk("race_new_mode", 32'(got[nx-1]), 32'd65025);

    cfg(8'h9C);
    waited = 1'b0;
    for (int i = 0; i < 8; i++) begin
      send(8'(i * 37 + 5), 8'(255 - i * 29));
    end
    drain();
    chk("b2b_no_stall", 32'(waited), 32'd0);
    nx = xfer_cyc.size();
    chk("b2b_consecutive", 32'(xfer_cyc[nx-1] - xfer_cyc[nx-8]), 32'd7);
    chk("b2b_op_count", 32'(op_count), 32'd10);
    chk("sat_op_count", 32'(op_count_s), 32'd7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
